// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, multicycle MDU stall, redirect flush, memory freeze.
// Latency: stall/flush/bubble outputs are combinational from state and inputs; state and counters update on the next edge.
// Backpressure: i_dmem_busy freezes the whole pipeline and the controller itself; nothing is consumed while frozen.

package cotm32_pkg;
    localparam int NUM_REGS = 32;
endpackage

module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32,
    localparam int RA          = $clog2(cotm32_pkg::NUM_REGS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_id_valid,
    input  logic [RA-1:0]     i_id_rs1_addr,
    input  logic [RA-1:0]     i_id_rs2_addr,
    input  logic              i_id_uses_rs1,
    input  logic              i_id_uses_rs2,
    input  logic              i_idex_valid,
    input  logic [RA-1:0]     i_idex_rd_addr,
    input  logic              i_idex_is_load,
    input  logic              i_idex_is_mdu,
    input  logic              i_mdu_done,
    input  logic              i_ex_redirect,
    input  logic              i_dmem_busy,
    output logic              o_pc_stall,
    output logic              o_ifid_stall,
    output logic              o_ifid_flush,
    output logic              o_idex_stall,
    output logic              o_idex_bubble,
    output logic              o_exmem_hold,
    output logic              o_exmem_bubble,
    output logic              o_mdu_start,
    output logic [1:0]        o_state,
    output logic [CNT_W-1:0]  o_stall_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MDU   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Counter holds the number of flush cycles still owed after the current one.
    localparam logic [3:0]       FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_e           state_q, state_d;
    logic [3:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             lu;

    // Load-use hazard: the ID instruction reads a register a load in ID/EX has not produced yet (x0 never hazards).
    always_comb begin
        lu = i_id_valid && i_idex_valid && i_idex_is_load && (i_idex_rd_addr != '0) &&
             ((i_id_uses_rs1 && (i_id_rs1_addr == i_idex_rd_addr)) ||
              (i_id_uses_rs2 && (i_id_rs2_addr == i_idex_rd_addr)));
    end

    // Priority-ordered control decode and next-state selection.
    always_comb begin
        o_pc_stall     = 1'b0;
        o_ifid_stall   = 1'b0;
        o_ifid_flush   = 1'b0;
        o_idex_stall   = 1'b0;
        o_idex_bubble  = 1'b0;
        o_exmem_hold   = 1'b0;
        o_exmem_bubble = 1'b0;
        o_mdu_start    = 1'b0;
        state_d        = state_q;
        fcnt_d         = fcnt_q;

        if (i_dmem_busy) begin
            // Memory wait freezes everything, including this FSM.
            o_pc_stall   = 1'b1;
            o_ifid_stall = 1'b1;
            o_idex_stall = 1'b1;
            o_exmem_hold = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (i_ex_redirect) begin
                        o_ifid_flush  = 1'b1;
                        o_idex_bubble = 1'b1;
                        fcnt_d        = FLUSH_RELOAD;
                        state_d       = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
                    end else if (i_idex_valid && i_idex_is_mdu) begin
                        o_mdu_start    = 1'b1;
                        o_pc_stall     = 1'b1;
                        o_ifid_stall   = 1'b1;
                        o_idex_stall   = 1'b1;
                        o_exmem_bubble = 1'b1;
                        state_d        = ST_MDU;
                    end else if (lu) begin
                        o_pc_stall    = 1'b1;
                        o_ifid_stall  = 1'b1;
                        o_idex_bubble = 1'b1;
                    end
                end
                ST_MDU: begin
                    if (i_mdu_done) begin
                        state_d = ST_RUN;
                    end else begin
                        o_pc_stall     = 1'b1;
                        o_ifid_stall   = 1'b1;
                        o_idex_stall   = 1'b1;
                        o_exmem_bubble = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    o_ifid_flush = 1'b1;
                    if (i_ex_redirect) begin
                        o_idex_bubble = 1'b1;
                        fcnt_d        = FLUSH_RELOAD;
                        state_d       = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
                    end else if (fcnt_q <= 4'd1) begin
                        fcnt_d  = 4'd0;
                        state_d = ST_RUN;
                    end else begin
                        fcnt_d = fcnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    fcnt_d  = 4'd0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC is held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (o_pc_stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    // State and counter registers with immediate asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_RUN;
            fcnt_q      <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_state       = state_q;
    assign o_stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int FC   = 2;
    localparam int CW   = 4;
    localparam int RA   = $clog2(cotm32_pkg::NUM_REGS);
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, uses1, uses2, idex_valid, is_load, is_mdu;
    logic          mdu_done, redirect, dmem_busy;
    logic [RA-1:0] rs1, rs2, rd;
    logic          pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble;
    logic          exmem_hold, exmem_bubble, mdu_start;
    logic [1:0]    state;
    logic [CW-1:0] scnt;

    int passed = 0;
    int total  = 0;

    // Reference model: mode 0=run, 1=waiting on MDU, 2=flushing; left = flush cycles owed after this one.
    int m_mode = 0;
    int m_left = 0;
    int m_cnt  = 0;

    hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_valid(id_valid), .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
        .i_id_uses_rs1(uses1), .i_id_uses_rs2(uses2),
        .i_idex_valid(idex_valid), .i_idex_rd_addr(rd),
        .i_idex_is_load(is_load), .i_idex_is_mdu(is_mdu),
        .i_mdu_done(mdu_done), .i_ex_redirect(redirect), .i_dmem_busy(dmem_busy),
        .o_pc_stall(pc_stall), .o_ifid_stall(ifid_stall), .o_ifid_flush(ifid_flush),
        .o_idex_stall(idex_stall), .o_idex_bubble(idex_bubble),
        .o_exmem_hold(exmem_hold), .o_exmem_bubble(exmem_bubble),
        .o_mdu_start(mdu_start), .o_state(state), .o_stall_count(scnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dut_outs();
        return {pc_stall, ifid_stall, ifid_flush, idex_stall,
                idex_bubble, exmem_hold, exmem_bubble, mdu_start};
    endfunction

    // Expected outputs in the same bit order as dut_outs(), plus the model's next mode/left.
    task automatic model_eval(output logic [7:0] eo, output int nm, output int nl);
        bit lu;
        lu = id_valid && idex_valid && is_load && (rd != 0) &&
             ((uses1 && rs1 == rd) || (uses2 && rs2 == rd));
        eo = 8'b0;
        nm = m_mode;
        nl = m_left;
        if (dmem_busy) begin
            eo = 8'b1101_0100;
        end else if (m_mode == 0) begin
            if (redirect) begin
                eo = 8'b0010_1000;
                nl = FC - 1;
                nm = (nl > 0) ? 2 : 0;
            end else if (idex_valid && is_mdu) begin
                eo = 8'b1101_0011;
                nm = 1;
            end else if (lu) begin
                eo = 8'b1100_1000;
            end
        end else if (m_mode == 1) begin
            if (mdu_done) nm = 0;
            else          eo = 8'b1101_0010;
        end else begin
            eo = {4'b0010, redirect, 3'b000};
            nl = redirect ? FC - 1 : m_left - 1;
            nm = (nl > 0) ? 2 : 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_inputs();
        id_valid = 0; uses1 = 0; uses2 = 0; idex_valid = 0; is_load = 0; is_mdu = 0;
        mdu_done = 0; redirect = 0; dmem_busy = 0; rs1 = '0; rs2 = '0; rd = '0;
    endtask

    // Entered 1 time unit after a rising edge; checks mid-cycle, then advances the model at the edge.
    task automatic step(input string tag);
        logic [7:0] eo;
        int nm, nl;
        #4;
        model_eval(eo, nm, nl);
        chk({tag, "_outs"}, 32'(dut_outs()), 32'(eo));
        chk({tag, "_state"}, 32'(state), 32'(m_mode));
        chk({tag, "_cnt"}, 32'(scnt), 32'(m_cnt));
        @(posedge clk);
        if (eo[7] && m_cnt < CMAX) m_cnt++;
        m_mode = nm;
        m_left = nl;
        #1;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1;
        #1;
        rst = 0;
        m_mode = 0; m_left = 0; m_cnt = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        #2;
        chk("reset_state", 32'(state), 0);
        chk("reset_cnt", 32'(scnt), 0);
        chk("reset_outs", 32'(dut_outs()), 0);
        // Outputs follow run rules while reset is held, but nothing is counted.
        id_valid = 1; uses1 = 1; rs1 = 5; idex_valid = 1; is_load = 1; rd = 5;
        #1;
        chk("reset_lu_outs", 32'(dut_outs()), 32'b1100_1000);
        @(posedge clk);
        #1;
        chk("reset_cnt_held", 32'(scnt), 0);
        apply_reset();

        // Load-use on rs1, then the load moves on.
        id_valid = 1; uses1 = 1; rs1 = 5; idex_valid = 1; is_load = 1; rd = 5;
        step("lu_hit");
        idex_valid = 0; is_load = 0;
        step("lu_after");
        chk("lu_count", 32'(scnt), 1);

        // No hazard on x0, nor on an rs2 that is not read.
        idex_valid = 1; is_load = 1; rd = 0; rs1 = 0;
        step("lu_x0");
        rd = 5; rs1 = 3; rs2 = 5; uses1 = 0; uses2 = 0;
        step("lu_rs2_unused");
        uses2 = 1;
        step("lu_rs2_used");

        // MDU op, done four cycles after the start pulse.
        apply_reset();
        idex_valid = 1; is_mdu = 1;
        step("mdu_start");
        for (int i = 0; i < 3; i++) step("mdu_wait");
        mdu_done = 1;
        step("mdu_done");
        idex_valid = 0; is_mdu = 0; mdu_done = 0;
        step("mdu_after");
        chk("mdu_count", 32'(scnt), 4);

        // Redirect flush, then a redirect arriving during the flush.
        apply_reset();
        redirect = 1;
        step("redir_run");
        redirect = 0;
        step("redir_flush");
        step("redir_back");
        redirect = 1;
        step("redir2_run");
        step("redir2_in_flush");
        redirect = 0;
        step("redir2_ext");
        step("redir2_back");
        chk("redir_state", 32'(state), 0);

        // Freeze in MDU with done already up; done taken once the freeze lifts.
        apply_reset();
        idex_valid = 1; is_mdu = 1;
        step("frz_start");
        dmem_busy = 1; mdu_done = 1; redirect = 1;
        for (int i = 0; i < 3; i++) step("frz_hold");
        dmem_busy = 0; redirect = 0;
        step("frz_done");
        chk("frz_count", 32'(scnt), 4);
        clear_inputs();
        step("frz_after");

        // Asynchronous reset between edges while in MDU.
        apply_reset();
        idex_valid = 1; is_mdu = 1;
        step("ar_start");
        step("ar_wait");
        #2;
        rst = 1;
        #1;
        chk("ar_state", 32'(state), 0);
        chk("ar_cnt", 32'(scnt), 0);
        rst = 0;
        clear_inputs();
        m_mode = 0; m_left = 0; m_cnt = 0;
        @(posedge clk);
        #1;
        step("ar_after");

        // Counter saturation under a persistent load-use hazard.
        id_valid = 1; uses1 = 1; rs1 = 7; idex_valid = 1; is_load = 1; rd = 7;
        for (int i = 0; i < CMAX + 4; i++) step("sat");
        chk("sat_count", 32'(scnt), CMAX);

        // Randomized traffic against the model.
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            id_valid   = ($urandom_range(0, 9) < 8);
            uses1      = $urandom_range(0, 1);
            uses2      = $urandom_range(0, 1);
            rs1        = RA'($urandom_range(0, 3));
            rs2        = RA'($urandom_range(0, 3));
            rd         = RA'($urandom_range(0, 3));
            idex_valid = ($urandom_range(0, 9) < 8);
            is_load    = $urandom_range(0, 1);
            is_mdu     = ($urandom_range(0, 9) < 2);
            mdu_done   = ($urandom_range(0, 9) < 3);
            redirect   = ($urandom_range(0, 99) < 15);
            dmem_busy  = ($urandom_range(0, 99) < 15);
            if (i % 97 == 0) apply_reset();
            step("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
